// File: rtl/chip8_pkg.sv
// ============================================================================
//  Module      : chip8_pkg
//  Description : Shared types and constants for the CHIP-8/SCHIP sprite
//                draw engine: draw FSM state encoding, pixel word fill
//                values and the default (low-res) screen geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chip8_pkg;

  // Draw FSM states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_PIX_RD = 3'd3,
    S_PIX_WR = 3'd4,
    S_DONE   = 3'd5
  } draw_state_t;

  // Fill bit of a pixel word; a lit pixel is this bit replicated PIXEL_W times
  localparam logic PIXEL_ON  = 1'b1;
  localparam logic PIXEL_OFF = 1'b0;

  // CHIP-8 low-res and SCHIP hi-res screen sizes
  localparam int SCREEN_W_DEFAULT = 64;
  localparam int SCREEN_H_DEFAULT = 32;
  localparam int SCREEN_W_SCHIP   = 128;
  localparam int SCREEN_H_SCHIP   = 64;

endpackage

`default_nettype wire

// File: rtl/chip8_sprite_engine_if.sv
// ============================================================================
//  Module      : chip8_sprite_engine_if
//  Description : Bus bundle between the sprite engine and its environment
//                (CPU start/status, program memory read port, vram port).
//                master : CPU + memories side
//                slave  : sprite engine side
//  Ports       : start_in, x_in, y_in, n_in, index_in, wrap_in  (request)
//                busy_out, done_out, collision_out                (status)
//                mem_rd_out, mem_addr_out, mem_data_in            (memory)
//                vram_rd_out, vram_we_out, vram_addr_out,
//                vram_rdata_in, vram_wdata_out                    (vram)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chip8_sprite_engine_if #(
  parameter int ADDR_W  = 12,
  parameter int PIXEL_W = 32,
  parameter int VADDR_W = 11
);
  import chip8_pkg::*;

  logic               start_in;
  logic [7:0]         x_in;
  logic [7:0]         y_in;
  logic [3:0]         n_in;
  logic [ADDR_W-1:0]  index_in;
  logic               wrap_in;
  logic               busy_out;
  logic               done_out;
  logic               collision_out;
  logic               mem_rd_out;
  logic [ADDR_W-1:0]  mem_addr_out;
  logic [7:0]         mem_data_in;
  logic               vram_rd_out;
  logic               vram_we_out;
  logic [VADDR_W-1:0] vram_addr_out;
  logic [PIXEL_W-1:0] vram_rdata_in;
  logic [PIXEL_W-1:0] vram_wdata_out;

  modport master (
    output start_in, x_in, y_in, n_in, index_in, wrap_in,
    output mem_data_in, vram_rdata_in,
    input  busy_out, done_out, collision_out,
    input  mem_rd_out, mem_addr_out,
    input  vram_rd_out, vram_we_out, vram_addr_out, vram_wdata_out
  );

  modport slave (
    input  start_in, x_in, y_in, n_in, index_in, wrap_in,
    input  mem_data_in, vram_rdata_in,
    output busy_out, done_out, collision_out,
    output mem_rd_out, mem_addr_out,
    output vram_rd_out, vram_we_out, vram_addr_out, vram_wdata_out
  );

endinterface

`default_nettype wire

// File: rtl/chip8_pixel_addr.sv
// ============================================================================
//  Module      : chip8_pixel_addr
//  Description : Combinational pixel locator. Adds the sprite column/row to
//                the origin and either wraps the result onto the screen or
//                flags it invisible when it falls off the right/bottom edge.
//  Ports       : ox_in, oy_in   sprite origin (already reduced mod screen)
//                col_in, row_in sprite-relative column / row (0..15)
//                wrap_in        1 = wrap, 0 = clip
//                visible_out    pixel lies on screen (always 1 when wrapping)
//                addr_out       y*SCREEN_W + x of the (wrapped) pixel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip8_pixel_addr
  import chip8_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT,
  parameter int XW       = $clog2(SCREEN_W),
  parameter int YW       = $clog2(SCREEN_H)
) (
  input  logic [XW-1:0]    ox_in,
  input  logic [YW-1:0]    oy_in,
  input  logic [3:0]       col_in,
  input  logic [3:0]       row_in,
  input  logic             wrap_in,
  output logic             visible_out,
  output logic [XW+YW-1:0] addr_out
);

  // Five spare bits hold the overflow past the screen edge (offset <= 15)
  logic [XW+4:0] px;
  logic [YW+4:0] py;

  assign px = (XW+5)'(ox_in) + (XW+5)'(col_in);
  assign py = (YW+5)'(oy_in) + (YW+5)'(row_in);

  // Screen sizes are powers of two, so overflow bits clear means on-screen
  assign visible_out = wrap_in | ((px[XW+4:XW] == 5'd0) && (py[YW+4:YW] == 5'd0));

  // Dropping the overflow bits is the modulo; concatenation is y*W + x
  assign addr_out = {py[YW-1:0], px[XW-1:0]};

endmodule

`default_nettype wire

// File: rtl/chip8_sprite_engine.sv
// ============================================================================
//  Module      : chip8_sprite_engine
//  Description : Multi-cycle CHIP-8/SCHIP DRW engine. Fetches sprite rows
//                from program memory and XOR-draws them into a word-per-pixel
//                framebuffer with one vram access per cycle, reporting
//                whether any lit pixel was turned off (collision).
//  Ports       : clk_in  clock, rising edge
//                rst_in  asynchronous active-high reset
//                bus     chip8_sprite_engine_if.slave (request, status,
//                        memory and vram ports)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip8_sprite_engine
  import chip8_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT,
  parameter int ADDR_W   = 12,
  parameter int PIXEL_W  = 32,
  parameter int SCHIP_EN = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  chip8_sprite_engine_if.slave bus
);

  localparam int XW      = $clog2(SCREEN_W);
  localparam int YW      = $clog2(SCREEN_H);
  localparam int VADDR_W = XW + YW;

  draw_state_t        state_q, state_d;
  logic [XW-1:0]      ox_q, ox_d;
  logic [YW-1:0]      oy_q, oy_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic               wide_q, wide_d;
  logic               byte_sel_q, byte_sel_d;
  logic [4:0]         rows_q, rows_d;
  logic [3:0]         row_q, row_d;
  logic [3:0]         col_q, col_d;
  logic [15:0]        bits_q, bits_d;
  logic               coll_q, coll_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               vram_rd_q, vram_rd_d;
  logic               vram_we_q, vram_we_d;
  logic [VADDR_W-1:0] vram_addr_q, vram_addr_d;

  logic               advance;
  logic [3:0]         last_col;
  logic [5:0]         offset;
  logic               pix_visible;
  logic [VADDR_W-1:0] pix_addr;

  // Locates the pixel the FSM is about to visit, so the vram read strobe
  // and address can be registered on entry to PIX_RD
  chip8_pixel_addr #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .XW       (XW),
    .YW       (YW)
  ) u_pixel_addr (
    .ox_in       (ox_d),
    .oy_in       (oy_d),
    .col_in      (col_d),
    .row_in      (row_d),
    .wrap_in     (wrap_d),
    .visible_out (pix_visible),
    .addr_out    (pix_addr)
  );

  assign last_col = wide_q ? 4'd15 : 4'd7;

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    idx_d      = idx_q;
    wrap_d     = wrap_q;
    wide_d     = wide_q;
    byte_sel_d = byte_sel_q;
    rows_d     = rows_q;
    row_d      = row_q;
    col_d      = col_q;
    bits_d     = bits_q;
    coll_d     = coll_q;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          // Origin always wraps: truncation is the modulo for power-of-2 screens
          ox_d       = XW'(bus.x_in);
          oy_d       = YW'(bus.y_in);
          idx_d      = bus.index_in;
          wrap_d     = bus.wrap_in;
          coll_d     = 1'b0;
          row_d      = 4'd0;
          col_d      = 4'd0;
          byte_sel_d = 1'b0;
          bits_d     = 16'h0000;
          if (bus.n_in != 4'd0) begin
            rows_d  = {1'b0, bus.n_in};
            wide_d  = 1'b0;
            state_d = S_FETCH;
          end else if (SCHIP_EN != 0) begin
            rows_d  = 5'd16;
            wide_d  = 1'b1;
            state_d = S_FETCH;
          end else begin
            rows_d  = 5'd0;
            wide_d  = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: begin
        // Leftmost byte lands in the top half so bit 15 is always the next pixel
        if (!byte_sel_q) begin
          bits_d = {bus.mem_data_in, 8'h00};
        end else begin
          bits_d = {bits_q[15:8], bus.mem_data_in};
        end
        if (wide_q && !byte_sel_q) begin
          byte_sel_d = 1'b1;
          state_d    = S_FETCH;
        end else begin
          byte_sel_d = 1'b0;
          col_d      = 4'd0;
          state_d    = S_PIX_RD;
        end
      end
      S_PIX_RD: begin
        // vram_rd_q was registered on entry, so it marks a pixel being drawn
        if (vram_rd_q) begin
          state_d = S_PIX_WR;
        end else begin
          advance = 1'b1;
        end
      end
      S_PIX_WR: begin
        if (bus.vram_rdata_in == {PIXEL_W{PIXEL_ON}}) begin
          coll_d = 1'b1;
        end
        advance = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (col_q == last_col) begin
        if (({1'b0, row_q} + 5'd1) == rows_q) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 4'd1;
          state_d = S_FETCH;
        end
      end else begin
        col_d   = col_q + 4'd1;
        bits_d  = {bits_q[14:0], 1'b0};
        state_d = S_PIX_RD;
      end
    end
  end

  // Registered outputs, decoded from the state being entered
  always_comb begin
    offset      = wide_d ? {1'b0, row_d, byte_sel_d} : {2'b00, row_d};
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_rd_d    = (state_d == S_FETCH);
    mem_addr_d  = mem_rd_d ? (idx_d + ADDR_W'(offset)) : mem_addr_q;
    vram_rd_d   = (state_d == S_PIX_RD) && bits_d[15] && pix_visible;
    vram_we_d   = (state_d == S_PIX_WR);
    // Address is held through PIX_WR so the write lands where the read was
    vram_addr_d = vram_rd_d ? pix_addr : vram_addr_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      ox_q        <= '0;
      oy_q        <= '0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
      wide_q      <= 1'b0;
      byte_sel_q  <= 1'b0;
      rows_q      <= 5'd0;
      row_q       <= 4'd0;
      col_q       <= 4'd0;
      bits_q      <= 16'h0000;
      coll_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      vram_rd_q   <= 1'b0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
      wide_q      <= wide_d;
      byte_sel_q  <= byte_sel_d;
      rows_q      <= rows_d;
      row_q       <= row_d;
      col_q       <= col_d;
      bits_q      <= bits_d;
      coll_q      <= coll_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      vram_rd_q   <= vram_rd_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
    end
  end

  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;
  assign bus.collision_out = coll_q;
  assign bus.mem_rd_out    = mem_rd_q;
  assign bus.mem_addr_out  = mem_addr_q;
  assign bus.vram_rd_out   = vram_rd_q;
  assign bus.vram_we_out   = vram_we_q;
  assign bus.vram_addr_out = vram_addr_q;
  // Read data only arrives in the PIX_WR cycle, so the inverted word is
  // formed combinationally there; the bus idles at zero otherwise
  assign bus.vram_wdata_out = vram_we_q ? (bus.vram_rdata_in ^ {PIXEL_W{PIXEL_ON}})
                                        : {PIXEL_W{PIXEL_OFF}};

endmodule

`default_nettype wire
